// File: rtl/fifo_defs.sv
// Shared definitions for the parametrised FIFO: read-mode encodings and
// an address-width helper that never collapses to zero bits.
package fifo_defs;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // A two-entry array still needs one address bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/generic_memory.sv
// Simple dual-port (1R1W) RAM with a registered, enable-gated read port.
// The read register holds its value whenever rd_en is low.
module generic_memory #(
    parameter int    SIZE            = 16,
    parameter int    ABITS           = 4,
    parameter int    WIDTH           = 8,
    parameter int    RD_PORTS        = 1,
    parameter int    WR_PORTS        = 1,
    parameter int    RD_TRANSPARENCY = 0,
    parameter string OPTION_RESET    = "NONE",
    parameter int    RD_ARST         = 0,
    parameter int    RD_SRST         = 0,
    parameter string MEMID           = "mem"
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_be,
    input  logic             rd_en,
    input  logic [ABITS-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Only the single-port, unreset flavour exists; any other setting
    // disables the array so a mis-configured instance is obvious at once.
    localparam bit CFG_OK = (RD_PORTS == 1) && (WR_PORTS == 1) &&
                            (OPTION_RESET == "NONE") && (RD_ARST == 0) &&
                            (RD_SRST == 0) && (MEMID != "");

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] wr_merged;

    assign wr_merged = (mem_q[wr_addr] & ~wr_be) | (wr_data & wr_be);

    always_ff @(posedge clk) begin
        if (CFG_OK && wr_en) begin
            mem_q[wr_addr] <= wr_merged;
        end
        if (CFG_OK && rd_en) begin
            if ((RD_TRANSPARENCY != 0) && wr_en && (wr_addr == rd_addr)) begin
                rd_data_q <= wr_merged;
            end else begin
                rd_data_q <= mem_q[rd_addr];
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO of any depth on one generic_memory, with standard or
// first-word-fall-through read, level flags, occupancy and sticky errors.
module sync_fifo_param
    import fifo_defs::*;
#(
    parameter int    WIDTH    = 32,
    parameter int    DEPTH    = 256,
    parameter int    FWFT     = 0,
    parameter int    AF_LEVEL = DEPTH - 1,
    parameter int    AE_LEVEL = 1,
    parameter string MEMID    = "fifo_mem",
    localparam int   ABITS    = clog2_min1(DEPTH),
    localparam int   CBITS    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CBITS-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam bit IS_FWFT = (FWFT == FIFO_MODE_FWFT);
    localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(DEPTH - 1);

    logic [ABITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CBITS-1:0] count_q, count_d, mem_cnt;
    logic             pop_valid_q, pop_valid_d;
    logic             seen_q, seen_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic             active, full_w, empty_w, no_data;
    logic             push_acc, pop_acc, rd_en;
    logic [WIDTH-1:0] mem_rd_data;

    function automatic logic [ABITS-1:0] ptr_inc(input logic [ABITS-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    // push is taken when !full; pop is taken when data is available
    // (standard: !empty, FWFT: pop_valid). Neither is taken in a flush cycle.
    always_comb begin
        active      = rst_n && !flush;
        full_w      = (count_q == CBITS'(DEPTH));
        empty_w     = (count_q == '0);
        mem_cnt     = count_q - CBITS'(pop_valid_q);
        push_acc    = active && push && !full_w;
        pop_acc     = 1'b0;
        rd_en       = 1'b0;
        pop_valid_d = 1'b0;
        no_data     = empty_w;
        if (IS_FWFT) begin
            // Refill the head register whenever it is empty or being consumed.
            no_data     = !pop_valid_q;
            pop_acc     = active && pop && pop_valid_q;
            rd_en       = active && (mem_cnt != '0) && (!pop_valid_q || pop_acc);
            pop_valid_d = rd_en ? 1'b1 : (pop_acc ? 1'b0 : pop_valid_q);
        end else begin
            pop_acc     = active && pop && !empty_w;
            rd_en       = pop_acc;
            pop_valid_d = rd_en;
        end
        overflow_d  = overflow_q  | (active && push && full_w);
        underflow_d = underflow_q | (active && pop && no_data);
        count_d     = count_q + CBITS'(push_acc) - CBITS'(pop_acc);
        wr_ptr_d    = push_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        seen_d      = seen_q | rd_en;
    end

    // seen_q masks the unreset memory read register until a real read lands;
    // flush keeps it so the last word stays visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            seen_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            seen_q      <= seen_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    generic_memory #(
        .SIZE            (DEPTH),
        .ABITS           (ABITS),
        .WIDTH           (WIDTH),
        .RD_PORTS        (1),
        .WR_PORTS        (1),
        .RD_TRANSPARENCY (0),
        .OPTION_RESET    ("NONE"),
        .RD_ARST         (0),
        .RD_SRST         (0),
        .MEMID           (MEMID)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (push_data),
        .wr_be   ({WIDTH{1'b1}}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    assign pop_data     = seen_q ? mem_rd_data : '0;
    assign pop_valid    = pop_valid_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= CBITS'(AF_LEVEL));
    assign almost_empty = (count_q <= CBITS'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
